// File: rtl/fp_dp_pkg.sv
// Shared definitions for the dot-product floating-point pipe: field widths,
// the packed binary32 layout and the special exponent/NaN encodings.
package fp_dp_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int SUM_W    = 52;
    localparam int NORM_POS = 46;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    localparam logic [EXP_W-1:0] INF_EXP = 8'hFF;
    localparam fp32_t QNAN = '{sign: 1'b0, exp: 8'hFF, frac: 23'h400000};

endpackage

// File: rtl/lzd52.sv
// Combinational leading-one detector for a 52-bit magnitude, built as a
// three-level tree of 4-bit detectors over a zero-padded 64-bit word.
module lzd52 (
    input  logic [51:0] value,
    output logic [5:0]  index,
    output logic        zero
);

    function automatic logic [1:0] lzd4(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    logic [63:0] padded;
    logic [15:0] nib_v;
    logic [1:0]  nib_pos [16];
    logic [3:0]  grp_v;
    logic [3:0]  grp_pos [4];
    logic [1:0]  grp_sel;
    logic [1:0]  top_sel;

    // Each group's position is its winning nibble index joined with that
    // nibble's local position; the top level repeats the trick over groups.
    always_comb begin
        padded  = {12'b0, value};
        grp_sel = 2'd0;
        for (int n = 0; n < 16; n++) begin
            nib_v[n]   = |padded[4*n +: 4];
            nib_pos[n] = lzd4(padded[4*n +: 4]);
        end
        for (int g = 0; g < 4; g++) begin
            grp_v[g]   = |nib_v[4*g +: 4];
            grp_sel    = lzd4(nib_v[4*g +: 4]);
            grp_pos[g] = {grp_sel, nib_pos[4*g + int'(grp_sel)]};
        end
        top_sel = lzd4(grp_v);
        index   = {top_sel, grp_pos[top_sel]};
        zero    = ~|grp_v;
    end

endmodule

// File: rtl/pipe_5_norm_round.sv
// Normalise, round-to-nearest-even and pack the dot-product sum as binary32,
// in two handshaked register stages that can stall on downstream back-pressure.
module pipe_5_norm_round
    import fp_dp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] sum_mul_all_pos,
    input  logic             sum_sign,
    input  logic [EXP_W-1:0] adder_exp_final,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      fp_result,
    output logic             exc_ovf,
    output logic             exc_unf
);

    logic [5:0]        msb;
    logic              sum_zero;
    logic [5:0]        shamt;
    logic [SUM_W-2:0]  mant_next;
    logic signed [9:0] exp_next;

    logic              v_a, sign_a, zero_a;
    logic [SUM_W-2:0]  mant_a;
    logic signed [9:0] exp_a;

    logic              v_b, ovf_b, unf_b;
    fp32_t             res_b;

    logic              a_load, b_load;
    logic [MAN_W-1:0]  frac_pre;
    logic              guard, sticky, round_up;
    logic [MAN_W:0]    frac_sum;
    logic signed [9:0] exp_r;
    fp32_t             res_next;
    logic              ovf_next, unf_next;

    lzd52 u_lzd (
        .value (sum_mul_all_pos),
        .index (msb),
        .zero  (sum_zero)
    );

    // The leading one is shifted out to bit SUM_W-1 and is implicit, so only
    // the bits below it are kept.
    assign shamt     = 6'(SUM_W - 1) - msb;
    assign mant_next = (SUM_W-1)'(sum_mul_all_pos << shamt);
    assign exp_next  = 10'(adder_exp_final) + 10'(msb) - 10'(NORM_POS);

    assign b_load   = !v_b || out_ready;
    assign a_load   = !v_a || b_load;
    assign in_ready = a_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_a    <= 1'b0;
            mant_a <= '0;
            exp_a  <= '0;
            sign_a <= 1'b0;
            zero_a <= 1'b0;
        end else if (a_load) begin
            v_a <= in_valid;
            if (in_valid) begin
                mant_a <= mant_next;
                exp_a  <= exp_next;
                sign_a <= sum_sign;
                zero_a <= sum_zero;
            end
        end
    end

    always_comb begin
        frac_pre = mant_a[SUM_W-2 -: MAN_W];
        guard    = mant_a[SUM_W-2-MAN_W];
        sticky   = |mant_a[SUM_W-3-MAN_W:0];
        round_up = guard && (sticky || frac_pre[0]);
        frac_sum = {1'b0, frac_pre} + {{MAN_W{1'b0}}, round_up};
        exp_r    = exp_a + 10'(frac_sum[MAN_W]);
        res_next = '{sign: sign_a, exp: exp_r[EXP_W-1:0], frac: frac_sum[MAN_W-1:0]};
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (zero_a) begin
            res_next = '0;
        end else if (exp_r >= 10'sd255) begin
            res_next = '{sign: sign_a, exp: INF_EXP, frac: '0};
            ovf_next = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            res_next = '{sign: sign_a, exp: '0, frac: '0};
            unf_next = 1'b1;
        end
    end

    // Result registers only move on a load, which keeps them frozen in a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_b   <= 1'b0;
            res_b <= '0;
            ovf_b <= 1'b0;
            unf_b <= 1'b0;
        end else if (b_load) begin
            v_b <= v_a;
            if (v_a) begin
                res_b <= res_next;
                ovf_b <= ovf_next;
                unf_b <= unf_next;
            end
        end
    end

    assign out_valid = v_b;
    assign fp_result = res_b;
    assign exc_ovf   = v_b && ovf_b;
    assign exc_unf   = v_b && unf_b;

endmodule

// File: tb/tb_pipe_5_norm_round.sv
// Directed bench for pipe_5_norm_round: exact values, rounding, exceptions,
// back-to-back streaming with a stall, and reset with results in flight.
module tb_pipe_5_norm_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [51:0] sum;
    logic        sum_sign;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_result;
    logic        exc_ovf;
    logic        exc_unf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [51:0] s;
        logic        sg;
        logic [7:0]  e;
        logic [31:0] r;
        logic        ovf;
        logic        unf;
    } vec_t;

    pipe_5_norm_round dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .sum_mul_all_pos (sum),
        .sum_sign        (sum_sign),
        .adder_exp_final (exp_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .fp_result       (fp_result),
        .exc_ovf         (exc_ovf),
        .exc_unf         (exc_unf)
    );

    always #5 clk = ~clk;

    // Present one input on an idle pipe and wait (bounded) for its result.
    task automatic run_one(input logic [51:0] s, input logic sg, input logic [7:0] e,
                           output logic [31:0] res, output logic ovf, output logic unf,
                           output int lat);
        @(negedge clk);
        sum = s; sum_sign = sg; exp_in = e; in_valid = 1'b1; out_ready = 1'b1;
        lat = -1; res = 'x; ovf = 1'bx; unf = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c; res = fp_result; ovf = exc_ovf; unf = exc_unf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sum = '0; sum_sign = 1'b0; exp_in = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || fp_result !== 32'h0 || exc_ovf !== 1'b0 || exc_unf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: valid=%b res=%h ovf=%b unf=%b, want 0 0 0 0",
                     out_valid, fp_result, exc_ovf, exc_unf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exact();
        vec_t v[4];
        logic [31:0] res; logic ovf, unf; int lat;
        v[0] = '{52'd1 << 46, 1'b0, 8'd127, 32'h3F800000, 1'b0, 1'b0};
        v[1] = '{(52'd1 << 46) | (52'd1 << 45), 1'b0, 8'd127, 32'h3FC00000, 1'b0, 1'b0};
        v[2] = '{52'd1 << 47, 1'b0, 8'd127, 32'h40000000, 1'b0, 1'b0};
        v[3] = '{52'd1 << 44, 1'b1, 8'd130, 32'hC0000000, 1'b0, 1'b0};
        foreach (v[i]) begin
            run_one(v[i].s, v[i].sg, v[i].e, res, ovf, unf, lat);
            checks++;
            if (res !== v[i].r || ovf !== v[i].ovf || unf !== v[i].unf) begin
                failures++;
                $display("[TB] FAIL exact_%0d: got %h ovf=%b unf=%b want %h ovf=%b unf=%b",
                         i, res, ovf, unf, v[i].r, v[i].ovf, v[i].unf);
            end
            checks++;
            if (lat != 2) begin
                failures++;
                $display("[TB] FAIL exact_latency_%0d: got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_rounding();
        vec_t v[4];
        logic [31:0] res; logic ovf, unf; int lat;
        v[0] = '{(52'd1 << 46) | (52'd1 << 22), 1'b0, 8'd127, 32'h3F800000, 1'b0, 1'b0};
        v[1] = '{(52'd1 << 46) | (52'd1 << 23) | (52'd1 << 22), 1'b0, 8'd127, 32'h3F800002, 1'b0, 1'b0};
        v[2] = '{(52'd1 << 47) - (52'd1 << 22), 1'b0, 8'd127, 32'h40000000, 1'b0, 1'b0};
        v[3] = '{(52'd1 << 46) | (52'd1 << 22) | 52'd1, 1'b0, 8'd127, 32'h3F800001, 1'b0, 1'b0};
        foreach (v[i]) begin
            run_one(v[i].s, v[i].sg, v[i].e, res, ovf, unf, lat);
            checks++;
            if (res !== v[i].r || ovf !== v[i].ovf || unf !== v[i].unf || lat < 0) begin
                failures++;
                $display("[TB] FAIL round_%0d: got %h ovf=%b unf=%b lat=%0d want %h ovf=%b unf=%b",
                         i, res, ovf, unf, lat, v[i].r, v[i].ovf, v[i].unf);
            end
        end
    endtask

    task automatic test_exceptions();
        vec_t v[4];
        logic [31:0] res; logic ovf, unf; int lat;
        v[0] = '{52'd1 << 47, 1'b0, 8'd254, 32'h7F800000, 1'b1, 1'b0};
        v[1] = '{52'd1 << 45, 1'b1, 8'd1, 32'h80000000, 1'b0, 1'b1};
        v[2] = '{52'd0, 1'b1, 8'd127, 32'h00000000, 1'b0, 1'b0};
        v[3] = '{(52'd1 << 47) - (52'd1 << 22), 1'b1, 8'd254, 32'hFF800000, 1'b1, 1'b0};
        foreach (v[i]) begin
            run_one(v[i].s, v[i].sg, v[i].e, res, ovf, unf, lat);
            checks++;
            if (res !== v[i].r || ovf !== v[i].ovf || unf !== v[i].unf || lat < 0) begin
                failures++;
                $display("[TB] FAIL exc_%0d: got %h ovf=%b unf=%b lat=%0d want %h ovf=%b unf=%b",
                         i, res, ovf, unf, lat, v[i].r, v[i].ovf, v[i].unf);
            end
        end
    endtask

    // Six inputs with exponents 127..132 stream while out_ready is held low
    // for cycles 3-5; each result is 2^(e-127) = {1'b0, e, 23'b0}.
    task automatic test_back_to_back();
        logic [31:0] expect_q [6];
        logic [31:0] held;
        logic        stalled;
        int sent, recv;
        bit saw_not_ready;
        for (int i = 0; i < 6; i++) expect_q[i] = {1'b0, 8'(127 + i), 23'b0};
        sent = 0; recv = 0; stalled = 1'b0; held = '0; saw_not_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 6);
            sum       = 52'd1 << 46;
            sum_sign  = 1'b0;
            exp_in    = 8'(127 + sent);
            #1;
            if (!in_ready) saw_not_ready = 1'b1;
            if (stalled) begin
                checks++;
                if (fp_result !== held) begin
                    failures++;
                    $display("[TB] FAIL stall_stable: got %h want %h", fp_result, held);
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checks++;
                if (fp_result !== expect_q[recv] || exc_ovf !== 1'b0 || exc_unf !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stream_%0d: got %h want %h", recv, fp_result, expect_q[recv]);
                end
                recv++;
            end
            stalled = out_valid && !out_ready;
            held    = fp_result;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (sent != 6 || recv != 6) begin
            failures++;
            $display("[TB] FAIL stream_count: sent=%0d recv=%0d want 6 6", sent, recv);
        end
        checks++;
        if (!saw_not_ready) begin
            failures++;
            $display("[TB] FAIL stream_backpressure: in_ready never dropped, want a drop");
        end
        for (int c = 0; c < 3; c++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_no_dup: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] res; logic ovf, unf; int lat;
        bit stale;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        sum = 52'd1 << 46; sum_sign = 1'b0; exp_in = 8'd140;
        @(negedge clk);
        exp_in = 8'd141;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL inflight_setup: out_valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fp_result !== 32'h0 || exc_ovf !== 1'b0 || exc_unf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: valid=%b res=%h ovf=%b unf=%b want 0 0 0 0",
                     out_valid, fp_result, exc_ovf, exc_unf);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("[TB] FAIL stale_after_reset: out_valid seen 1, want 0");
        end
        run_one(52'd1 << 46, 1'b0, 8'd128, res, ovf, unf, lat);
        checks++;
        if (res !== 32'h40000000 || lat != 2) begin
            failures++;
            $display("[TB] FAIL post_reset: got %h lat=%0d want 40000000 lat=2", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_rounding();
        test_exceptions();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_5_norm_round.md
Name: pipe_5_norm_round

Overview:
Downstream stage after the dot-product L2 adder. Takes the aligned, magnitude-converted sum (52-bit unsigned), its sign and the common exponent. It then:
- normalises the sum by leading-one detection and shift,
- rounds to nearest-even,
- handles zero, overflow and underflow,
- packs an IEEE-754 binary32 result.

Two internal register stages with a valid/ready handshake so the dot-product pipe can stall.

Parameters:
- SUM_W, 52, width of incoming magnitude.
- NORM_POS, 46, bit index the hidden one occupies when the sum needs no exponent change.
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream sum/exp/sign valid this cycle.
- in_ready  out  1  stage can accept input this cycle.
- sum_mul_all_pos  in  SUM_W  magnitude of sum.
- sum_sign  in  1  sign of sum (bit 51 of the two's-complement sum).
- adder_exp_final  in  EXP_W  biased exponent associated with NORM_POS.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- fp_result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- exc_ovf  out  1  result overflowed to infinity.
- exc_unf  out  1  result flushed to zero from nonzero sum.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, all valid bits, fp_result, exc_ovf and exc_unf are 0.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage A (registered):
  - msb = index of highest set bit of sum_mul_all_pos; is_zero when sum = 0.
  - Store mantissa shifted left so the leading one sits at bit SUM_W-1.
  - Store exp_a = adder_exp_final + msb - NORM_POS as a 10-bit signed value (range -46..260).
  - Store sign and is_zero.
- Stage B (registered, drives outputs):
  - frac = bits [50:28]; guard = bit 27; sticky = OR of bits [26:0].
  - Round up when guard && (sticky || frac[0]).
  - If rounding carries out of frac, frac becomes 0 and exp increments by 1.
- Exception handling, in priority order:
  - is_zero: output {sign=0, 0}; no flag raised.
  - exp >= 255 after rounding: output {sign, 8'hFF, 0} with exc_ovf=1.
  - exp <= 0: output {sign, 0, 0} (signed zero, no subnormals) with exc_unf=1.
  - Otherwise: output {sign, exp[7:0], frac}.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 result per cycle.
- Flow control:
  - Each stage holds its contents while the next stage is full and not draining.
  - in_ready = !vA || !vB || out_ready (combinational).
  - Stage B loads when !vB || out_ready.
  - Simultaneous accept and drain in the same cycle keeps full throughput.
- Stall: outputs are stable (no change to fp_result or flags) while out_valid && !out_ready.
- Reset mid-operation discards in-flight results. No output is produced for them after release.
- Flags are qualified by out_valid and are 0 when out_valid=0.

Decomposition:
- Shared package fp_dp_pkg holds:
  - EXP_W, MAN_W, BIAS=127, SUM_W, NORM_POS,
  - the FP32 packed struct/typedef,
  - the constants INF_EXP=8'hFF and QNAN.
- One sub-module: lzd52, a combinational leading-one detector. It outputs a 6-bit index and a zero flag, built as a tree of 4-bit detectors. The normaliser, rounder, exception logic and handshake stay in pipe_5_norm_round.

Test Plan:
- Exact value: sum=1<<46, exp=127, sign=0 -> fp_result=0x3F800000 two cycles later; sum=(1<<46)|(1<<45) -> 0x3FC00000.
- Carry-in sum: sum=1<<47, exp=127 -> 0x40000000. Negative input: sign=1, sum=1<<44, exp=130 -> 0xC0000000.
- Rounding:
  - (1<<46)|(1<<22), exp=127 -> 0x3F800000 (tie, even).
  - (1<<46)|(1<<23)|(1<<22) -> 0x3F800002.
  - sum with bits 46..22 all ones -> 0x40000000 (mantissa round carry).
- Exceptions:
  - exp=254, sum=1<<47 -> 0x7F800000, exc_ovf=1.
  - exp=1, sum=1<<45, sign=1 -> 0x80000000, exc_unf=1.
  - sum=0, sign=1 -> 0x00000000, no flags.
- Handshake: stream 6 back-to-back inputs with out_ready low for cycles 3-5. Required: no loss or duplication; in_ready drops once both stages are full; results emerge in order; fp_result is stable during the stall.
- Reset: assert rst_n=0 with 2 results in flight. Required: out_valid=0 immediately (asynchronous); no stale result after release; the first new input yields its correct result 2 cycles later.
